// File: rtl/serdes_eye_window_search.sv
// Lock-mask eye search for one SERDES lane: scans every bitslip's delay-tap pass
// mask for its longest passing window and reports the widest eye and lock status.
module serdes_eye_window_search #(
    parameter int    MASK_W   = 32,
    parameter int    NUM_SLIP = 12,
    parameter int    ADDR_W   = 4,
    parameter int    READ_LAT = 1,
    parameter int    WRAP_EN  = 0,
    parameter string DEBUG    = "FALSE"
) (
    input  logic              px_clk,
    input  logic              px_reset,
    input  logic [7:0]        EYE_RANGE,
    input  logic              start,
    output logic              busy_out,
    input  logic [MASK_W-1:0] lock_mask_din,
    output logic [ADDR_W-1:0] lock_mask_raddr_out,
    output logic              lock_mask_ren_out,
    output logic [7:0]        delay_min_dout,
    output logic [7:0]        delay_max_dout,
    output logic [7:0]        delay_range_dout,
    output logic [ADDR_W-1:0] delay_data_waddr_out,
    output logic              delay_data_we_out,
    output logic [7:0]        best_delay_out,
    output logic [7:0]        best_slip_out,
    output logic [7:0]        best_range_out,
    output logic              lock_out,
    output logic              done_out
);

    localparam int                SCAN_LEN  = MASK_W * (1 + WRAP_EN);
    localparam logic [8:0]        LAST_IDX  = 9'(SCAN_LEN - 1);
    localparam logic [8:0]        MASK_W9   = 9'(MASK_W);
    localparam logic [7:0]        MASK_W8   = 8'(MASK_W);
    localparam logic [7:0]        LAST_WAIT = 8'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_SLIP = ADDR_W'(NUM_SLIP - 1);
    localparam logic [MASK_W-1:0] ONE_TAP   = MASK_W'(1);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, LOAD, SCAN, WRITE, EVAL, DONE} state_t;

    state_t            r_state, w_stateN;
    logic [ADDR_W-1:0] r_slip, w_slipN;
    logic [7:0]        r_waitCnt, w_waitCntN;
    logic [MASK_W-1:0] r_mask, w_maskN;
    logic [8:0]        r_idx, w_idxN;
    logic [7:0]        r_curStart, w_curStartN, r_curLen, w_curLenN;
    logic [7:0]        r_winStart, w_winStartN, r_winLen, w_winLenN;
    logic              r_busy, w_busyN, r_ren, w_renN, r_we, w_weN;
    logic              r_lock, w_lockN, r_done, w_doneN;
    logic [ADDR_W-1:0] r_raddr, w_raddrN, r_waddr, w_waddrN;
    logic [7:0]        r_dmin, w_dminN, r_dmax, w_dmaxN, r_drange, w_drangeN;
    logic [7:0]        r_bestDelay, w_bestDelayN, r_bestSlip, w_bestSlipN;
    logic [7:0]        r_bestRange, w_bestRangeN;

    logic [8:0] w_bitPos;
    logic       w_bit;
    logic [7:0] w_scanStart, w_scanLen;
    logic [7:0] w_endSum, w_delayMax, w_ctrSum, w_center, w_bestRangeUpd;
    logic       w_takeBest;

    // In circular mode the second pass re-reads the mask so windows can cross tap 0.
    assign w_bitPos = (r_idx < MASK_W9) ? r_idx : r_idx - MASK_W9;
    assign w_bit    = |(r_mask & (ONE_TAP << w_bitPos));

    assign w_endSum   = r_winStart + r_winLen - 8'd1;
    assign w_delayMax = (r_winLen == 8'd0) ? 8'd0 :
                        (w_endSum >= MASK_W8) ? w_endSum - MASK_W8 : w_endSum;
    assign w_ctrSum   = r_dmin + {1'b0, r_drange[7:1]};
    assign w_center   = (w_ctrSum >= MASK_W8) ? w_ctrSum - MASK_W8 : w_ctrSum;

    assign w_takeBest     = (r_drange > r_bestRange);
    assign w_bestRangeUpd = w_takeBest ? r_drange : r_bestRange;

    always_comb begin
        w_scanStart = r_curStart;
        w_scanLen   = r_curLen;
        if (w_bit) begin
            // A run may only open on the first pass; the wrap pass only extends it.
            if (r_curLen == 8'd0) begin
                if (r_idx < MASK_W9) begin
                    w_scanStart = r_idx[7:0];
                    w_scanLen   = 8'd1;
                end
            end else if (r_curLen < MASK_W8) begin
                w_scanLen = r_curLen + 8'd1;
            end
        end else begin
            w_scanLen = 8'd0;
        end
    end

    always_comb begin
        w_stateN     = r_state;
        w_slipN      = r_slip;
        w_waitCntN   = r_waitCnt;
        w_maskN      = r_mask;
        w_idxN       = r_idx;
        w_curStartN  = r_curStart;
        w_curLenN    = r_curLen;
        w_winStartN  = r_winStart;
        w_winLenN    = r_winLen;
        w_busyN      = r_busy;
        w_renN       = 1'b0;
        w_weN        = 1'b0;
        w_doneN      = 1'b0;
        w_lockN      = r_lock;
        w_raddrN     = r_raddr;
        w_waddrN     = r_waddr;
        w_dminN      = r_dmin;
        w_dmaxN      = r_dmax;
        w_drangeN    = r_drange;
        w_bestDelayN = r_bestDelay;
        w_bestSlipN  = r_bestSlip;
        w_bestRangeN = r_bestRange;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_busyN      = 1'b1;
                    w_bestDelayN = 8'd0;
                    w_bestSlipN  = 8'd0;
                    w_bestRangeN = 8'd0;
                    w_lockN      = 1'b0;
                    w_slipN      = '0;
                    w_stateN     = ADDR;
                end
            end
            ADDR: begin
                w_raddrN   = r_slip;
                w_renN     = 1'b1;
                w_waitCntN = 8'd0;
                w_stateN   = WAIT;
            end
            WAIT: begin
                if (r_waitCnt == LAST_WAIT) w_stateN = LOAD;
                else                        w_waitCntN = r_waitCnt + 8'd1;
            end
            LOAD: begin
                w_maskN     = lock_mask_din;
                w_idxN      = 9'd0;
                w_curStartN = 8'd0;
                w_curLenN   = 8'd0;
                w_winStartN = 8'd0;
                w_winLenN   = 8'd0;
                w_stateN    = SCAN;
            end
            SCAN: begin
                w_curStartN = w_scanStart;
                w_curLenN   = w_scanLen;
                if (w_scanLen > r_winLen) begin
                    w_winStartN = w_scanStart;
                    w_winLenN   = w_scanLen;
                end
                w_idxN = r_idx + 9'd1;
                if (r_idx == LAST_IDX) w_stateN = WRITE;
            end
            WRITE: begin
                w_dminN   = r_winStart;
                w_drangeN = r_winLen;
                w_dmaxN   = w_delayMax;
                w_waddrN  = r_slip;
                w_weN     = 1'b1;
                w_stateN  = EVAL;
            end
            EVAL: begin
                if (w_takeBest) begin
                    w_bestRangeN = r_drange;
                    w_bestSlipN  = 8'(r_slip);
                    w_bestDelayN = w_center;
                end
                if (r_slip == LAST_SLIP) begin
                    w_lockN  = (w_bestRangeUpd >= EYE_RANGE) && (w_bestRangeUpd != 8'd0);
                    w_doneN  = 1'b1;
                    w_stateN = DONE;
                end else begin
                    w_slipN  = r_slip + 1'b1;
                    w_stateN = ADDR;
                end
            end
            DONE: begin
                w_busyN  = 1'b0;
                w_stateN = IDLE;
            end
            default: w_stateN = IDLE;
        endcase
    end

    always_ff @(posedge px_clk) begin
        if (px_reset) begin
            r_state     <= IDLE;
            r_slip      <= '0;
            r_waitCnt   <= 8'd0;
            r_mask      <= '0;
            r_idx       <= 9'd0;
            r_curStart  <= 8'd0;
            r_curLen    <= 8'd0;
            r_winStart  <= 8'd0;
            r_winLen    <= 8'd0;
            r_busy      <= 1'b0;
            r_ren       <= 1'b0;
            r_we        <= 1'b0;
            r_lock      <= 1'b0;
            r_done      <= 1'b0;
            r_raddr     <= '0;
            r_waddr     <= '0;
            r_dmin      <= 8'd0;
            r_dmax      <= 8'd0;
            r_drange    <= 8'd0;
            r_bestDelay <= 8'd0;
            r_bestSlip  <= 8'd0;
            r_bestRange <= 8'd0;
        end else begin
            r_state     <= w_stateN;
            r_slip      <= w_slipN;
            r_waitCnt   <= w_waitCntN;
            r_mask      <= w_maskN;
            r_idx       <= w_idxN;
            r_curStart  <= w_curStartN;
            r_curLen    <= w_curLenN;
            r_winStart  <= w_winStartN;
            r_winLen    <= w_winLenN;
            r_busy      <= w_busyN;
            r_ren       <= w_renN;
            r_we        <= w_weN;
            r_lock      <= w_lockN;
            r_done      <= w_doneN;
            r_raddr     <= w_raddrN;
            r_waddr     <= w_waddrN;
            r_dmin      <= w_dminN;
            r_dmax      <= w_dmaxN;
            r_drange    <= w_drangeN;
            r_bestDelay <= w_bestDelayN;
            r_bestSlip  <= w_bestSlipN;
            r_bestRange <= w_bestRangeN;
        end
    end

    assign busy_out             = r_busy;
    assign lock_mask_raddr_out  = r_raddr;
    assign lock_mask_ren_out    = r_ren;
    assign delay_min_dout       = r_dmin;
    assign delay_max_dout       = r_dmax;
    assign delay_range_dout     = r_drange;
    assign delay_data_waddr_out = r_waddr;
    assign delay_data_we_out    = r_we;
    assign best_delay_out       = r_bestDelay;
    assign best_slip_out        = r_bestSlip;
    assign best_range_out       = r_bestRange;
    assign lock_out             = r_lock;
    assign done_out             = r_done;

    generate
        if (DEBUG == "TRUE") begin : g_debug
            (* mark_debug = "true" *) logic [2:0]        r_dbgState;
            (* mark_debug = "true" *) logic [ADDR_W-1:0] r_dbgSlip;
            (* mark_debug = "true" *) logic [7:0]        r_dbgWinLen;
            always_ff @(posedge px_clk) begin
                r_dbgState  <= r_state;
                r_dbgSlip   <= r_slip;
                r_dbgWinLen <= r_winLen;
            end
        end
    endgenerate

endmodule

// File: tb/tb_serdes_eye_window_search.sv
// Directed bench for the eye search: default, circular-mask and two-cycle RAM
// latency instances, each fed by a small lock-mask RAM model.
`timescale 1ns/1ps
module tb_serdes_eye_window_search;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       start    = '0;
    logic [2:0][7:0]  eyeRange = '0;
    logic [2:0][31:0] din;
    logic [2:0]       busy, ren, we, lock, done;
    logic [2:0][3:0]  raddr, waddr;
    logic [2:0][7:0]  dmin, dmax, drange, bestDelay, bestSlip, bestRange;

    logic [31:0]     mem [3][16];
    logic [2:0]      v1;
    logic [2:0][3:0] a1;

    int cyc = 0;
    int testsRun = 0;
    int testsFailed = 0;
    int startEdge [3];
    int renCount [3];
    int renCyc [3][16];
    int wrCount [3];
    int wrCyc [3][16];
    logic [7:0] wrMin [3][16];
    logic [7:0] wrMax [3][16];
    logic [7:0] wrRange [3][16];
    logic [2:0] busyWatch = '0;
    int busyGap [3];

    serdes_eye_window_search dut0 (
        .px_clk(clk), .px_reset(rst), .EYE_RANGE(eyeRange[0]), .start(start[0]),
        .busy_out(busy[0]), .lock_mask_din(din[0]), .lock_mask_raddr_out(raddr[0]),
        .lock_mask_ren_out(ren[0]), .delay_min_dout(dmin[0]), .delay_max_dout(dmax[0]),
        .delay_range_dout(drange[0]), .delay_data_waddr_out(waddr[0]),
        .delay_data_we_out(we[0]), .best_delay_out(bestDelay[0]),
        .best_slip_out(bestSlip[0]), .best_range_out(bestRange[0]),
        .lock_out(lock[0]), .done_out(done[0]));

    serdes_eye_window_search #(.WRAP_EN(1)) dut1 (
        .px_clk(clk), .px_reset(rst), .EYE_RANGE(eyeRange[1]), .start(start[1]),
        .busy_out(busy[1]), .lock_mask_din(din[1]), .lock_mask_raddr_out(raddr[1]),
        .lock_mask_ren_out(ren[1]), .delay_min_dout(dmin[1]), .delay_max_dout(dmax[1]),
        .delay_range_dout(drange[1]), .delay_data_waddr_out(waddr[1]),
        .delay_data_we_out(we[1]), .best_delay_out(bestDelay[1]),
        .best_slip_out(bestSlip[1]), .best_range_out(bestRange[1]),
        .lock_out(lock[1]), .done_out(done[1]));

    serdes_eye_window_search #(.READ_LAT(2)) dut2 (
        .px_clk(clk), .px_reset(rst), .EYE_RANGE(eyeRange[2]), .start(start[2]),
        .busy_out(busy[2]), .lock_mask_din(din[2]), .lock_mask_raddr_out(raddr[2]),
        .lock_mask_ren_out(ren[2]), .delay_min_dout(dmin[2]), .delay_max_dout(dmax[2]),
        .delay_range_dout(drange[2]), .delay_data_waddr_out(waddr[2]),
        .delay_data_we_out(we[2]), .best_delay_out(bestDelay[2]),
        .best_slip_out(bestSlip[2]), .best_range_out(bestRange[2]),
        .lock_out(lock[2]), .done_out(done[2]));

    // RAM models: read data is valid for exactly one cycle after the latency,
    // all-ones otherwise, so a capture on the wrong cycle shows up as a wide eye.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        v1  <= ren;
        a1  <= raddr;
        din[0] <= ren[0] ? mem[0][raddr[0]] : 32'hFFFF_FFFF;
        din[1] <= ren[1] ? mem[1][raddr[1]] : 32'hFFFF_FFFF;
        din[2] <= v1[2]  ? mem[2][a1[2]]    : 32'hFFFF_FFFF;
    end

    // Logs read strobes and result writes by cycle relative to the accepted start.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ren[d] === 1'b1) begin
                if (renCount[d] < 16) renCyc[d][renCount[d]] = cyc - startEdge[d];
                renCount[d] = renCount[d] + 1;
            end
            if (we[d] === 1'b1) begin
                wrCount[d] = wrCount[d] + 1;
                wrMin[d][waddr[d]]   = dmin[d];
                wrMax[d][waddr[d]]   = dmax[d];
                wrRange[d][waddr[d]] = drange[d];
                wrCyc[d][waddr[d]]   = cyc - startEdge[d];
            end
            if (busyWatch[d] && busy[d] !== 1'b1) busyGap[d] = busyGap[d] + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearLog(input int d);
        renCount[d] = 0;
        wrCount[d]  = 0;
        busyGap[d]  = 0;
        for (int i = 0; i < 16; i++) begin
            renCyc[d][i]  = -1;
            wrCyc[d][i]   = -1;
            wrMin[d][i]   = 8'hAA;
            wrMax[d][i]   = 8'hAA;
            wrRange[d][i] = 8'hAA;
        end
    endtask

    task automatic clearMasks();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
    endtask

    task automatic applyStimulus(input int d, input logic [7:0] er, input bit hold);
        @(negedge clk);
        clearLog(d);
        eyeRange[d]  = er;
        start[d]     = 1'b1;
        startEdge[d] = cyc;
        @(negedge clk);
        checkOutput($sformatf("busy_c1_d%0d", d), busy[d], 1);
        checkOutput($sformatf("lock_cleared_d%0d", d), lock[d], 0);
        if (!hold) start[d] = 1'b0;
    endtask

    task automatic checkDone(input int d, input int expCyc, input int expSlip,
                             input int expDelay, input int expRange, input logic expLock);
        int n = 0;
        int rel = -1;
        while (done[d] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (done[d] === 1'b1) rel = cyc - startEdge[d];
        start[d]     = 1'b0;
        busyWatch[d] = 1'b0;
        checkOutput($sformatf("done_cycle_d%0d", d), rel, expCyc);
        checkOutput($sformatf("best_slip_d%0d", d), bestSlip[d], expSlip);
        checkOutput($sformatf("best_delay_d%0d", d), bestDelay[d], expDelay);
        checkOutput($sformatf("best_range_d%0d", d), bestRange[d], expRange);
        checkOutput($sformatf("lock_d%0d", d), lock[d], expLock);
        checkOutput($sformatf("busy_at_done_d%0d", d), busy[d], 1);
        @(negedge clk);
        checkOutput($sformatf("done_pulse_d%0d", d), done[d], 0);
        checkOutput($sformatf("busy_after_done_d%0d", d), busy[d], 0);
    endtask

    task automatic checkWrite(input int d, input int slip, input int expMin,
                              input int expMax, input int expRange, input int expCyc);
        checkOutput($sformatf("wr_min_d%0d_s%0d", d, slip), wrMin[d][slip], expMin);
        checkOutput($sformatf("wr_max_d%0d_s%0d", d, slip), wrMax[d][slip], expMax);
        checkOutput($sformatf("wr_range_d%0d_s%0d", d, slip), wrRange[d][slip], expRange);
        checkOutput($sformatf("wr_cycle_d%0d_s%0d", d, slip), wrCyc[d][slip], expCyc);
    endtask

    initial begin
        logic [7:0] orAll;
        int n;
        clearMasks();
        for (int d = 0; d < 3; d++) begin
            clearLog(d);
            startEdge[d] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++)
            checkOutput($sformatf("reset_zero_d%0d", d),
                        {31'd0, |{busy[d], ren[d], we[d], lock[d], done[d], raddr[d], waddr[d],
                                  dmin[d], dmax[d], drange[d], bestDelay[d], bestSlip[d],
                                  bestRange[d]}}, 0);
        rst = 1'b0;

        // Single window on slip 5
        mem[0][5] = 32'h0000_FF00;
        applyStimulus(0, 8'd6, 1'b0);
        checkDone(0, 445, 5, 12, 8, 1'b1);
        checkWrite(0, 5, 8, 15, 8, 222);
        checkWrite(0, 0, 0, 0, 0, 37);
        checkOutput("first_ren_cycle", renCyc[0][0], 2);
        checkOutput("ren_count", renCount[0], 12);
        checkOutput("we_count", wrCount[0], 12);

        // Equal windows on slips 2 and 7, threshold above the width
        clearMasks();
        mem[0][2] = 32'h000F_FC00;
        mem[0][7] = 32'h000F_FC00;
        applyStimulus(0, 8'd11, 1'b0);
        checkDone(0, 445, 2, 15, 10, 1'b0);
        checkWrite(0, 7, 10, 19, 10, 296);

        // Edge-split mask without wrap; smaller eye than the previous run
        clearMasks();
        mem[0][0] = 32'hF000_000F;
        applyStimulus(0, 8'd4, 1'b0);
        checkDone(0, 445, 0, 2, 4, 1'b1);
        checkWrite(0, 0, 0, 3, 4, 37);

        // All-ones mask with start held high for the whole search
        clearMasks();
        mem[0][0] = 32'hFFFF_FFFF;
        applyStimulus(0, 8'd20, 1'b1);
        busyWatch[0] = 1'b1;
        checkDone(0, 445, 0, 16, 32, 1'b1);
        checkWrite(0, 0, 0, 31, 32, 37);
        checkOutput("held_start_busy_gap", busyGap[0], 0);
        repeat (4) @(negedge clk);
        checkOutput("held_start_no_restart", busy[0], 0);
        checkOutput("held_start_ren_count", renCount[0], 12);

        // All-zero masks with zero threshold
        clearMasks();
        applyStimulus(0, 8'd0, 1'b0);
        checkDone(0, 445, 0, 0, 0, 1'b0);
        orAll = 8'd0;
        for (int i = 0; i < 12; i++) orAll = orAll | wrMin[0][i] | wrMax[0][i] | wrRange[0][i];
        checkOutput("zero_writes_or", orAll, 0);
        checkOutput("zero_we_count", wrCount[0], 12);

        // Reset during the scan of slip 3
        clearMasks();
        mem[0][1] = 32'h0000_FF00;
        applyStimulus(0, 8'd4, 1'b0);
        n = 0;
        while ((cyc - startEdge[0]) < 121 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pre_reset_cycle", cyc - startEdge[0], 121);
        checkOutput("pre_reset_busy", busy[0], 1);
        checkOutput("pre_reset_best_range", bestRange[0], 8);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_zero",
                    {31'd0, |{busy[0], ren[0], we[0], lock[0], done[0], raddr[0], waddr[0],
                              dmin[0], dmax[0], drange[0], bestDelay[0], bestSlip[0],
                              bestRange[0]}}, 0);
        rst = 1'b0;
        renCount[0] = 0;
        wrCount[0]  = 0;
        repeat (80) @(negedge clk);
        checkOutput("post_reset_ren", renCount[0], 0);
        checkOutput("post_reset_we", wrCount[0], 0);
        checkOutput("post_reset_busy", busy[0], 0);

        // Circular mask instance
        clearMasks();
        mem[1][0] = 32'hF000_000F;
        applyStimulus(1, 8'd8, 1'b0);
        checkDone(1, 829, 0, 0, 8, 1'b1);
        checkWrite(1, 0, 28, 3, 8, 69);

        // Two-cycle read latency instance
        clearMasks();
        mem[2][0] = 32'h0000_FF00;
        applyStimulus(2, 8'd8, 1'b0);
        checkDone(2, 457, 0, 12, 8, 1'b1);
        checkWrite(2, 0, 8, 15, 8, 38);
        checkWrite(2, 1, 0, 0, 0, 76);
        checkOutput("rl2_ren0", renCyc[2][0], 2);
        checkOutput("rl2_ren1", renCyc[2][1], 40);
        checkOutput("rl2_ren2", renCyc[2][2], 78);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
